// File: rtl/store_buffer_lsu.sv
// Load/store unit in front of a 256x16 data RAM: stores queue in an in-order
// buffer that drains through the write port, loads forward from the youngest match.
module store_buffer_lsu #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        sb_empty,
   output logic [15:0] mem_access_addr,
   output logic [15:0] mem_write_data,
   output logic        mem_write_en,
   output logic        mem_read,
   input  logic [15:0] mem_read_data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [7:0]  r_widx [DEPTH];
   logic [15:0] r_addr [DEPTH];
   logic [15:0] r_data [DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        r_rspValid;
   logic [15:0] r_rspData;

   logic [AW:0]   w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_accept;
   logic          w_load;
   logic          w_store;
   logic          w_drain;
   logic [AW-1:0] w_head;
   logic [AW-1:0] w_tail;
   logic          w_fwdHit;
   logic [15:0]   w_fwdData;
   logic [15:0]   w_loadData;

   // Pointers carry one extra bit so their difference distinguishes full from empty.
   assign w_count  = r_wptr - r_rptr;
   assign w_full   = (w_count == FULL_COUNT);
   assign w_empty  = (w_count == '0);
   assign w_head   = r_rptr[AW-1:0];
   assign w_tail   = r_wptr[AW-1:0];

   assign req_ready = !reset && !w_full;
   assign w_accept  = req_valid && req_ready;
   assign w_load    = w_accept && !req_we;
   assign w_store   = w_accept && req_we;
   // A load owns the RAM port; buffered stores are never written while reset is high.
   assign w_drain   = !reset && !w_load && !w_empty;

   assign sb_empty  = w_empty;
   assign rsp_valid = r_rspValid;
   assign rsp_data  = r_rspData;

   // Walk oldest to youngest so the last match, the youngest store, wins.
   always_comb begin
      w_fwdHit  = 1'b0;
      w_fwdData = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (((AW+1)'(k) < w_count) &&
             (r_widx[w_head + AW'(k)] == req_addr[8:1])) begin
            w_fwdHit  = 1'b1;
            w_fwdData = r_data[w_head + AW'(k)];
         end
      end
   end

   assign w_loadData = w_fwdHit ? w_fwdData : mem_read_data;

   always_comb begin
      mem_read        = w_load;
      mem_write_en    = w_drain;
      mem_access_addr = '0;
      mem_write_data  = '0;
      if (w_load) begin
         mem_access_addr = req_addr;
      end else if (w_drain) begin
         mem_access_addr = r_addr[w_head];
         mem_write_data  = r_data[w_head];
      end
   end

   // Entry storage needs no reset; the pointers decide which slots are live.
   always_ff @(posedge clk) begin
      if (w_store) begin
         r_widx[w_tail] <= req_addr[8:1];
         r_addr[w_tail] <= req_addr;
         r_data[w_tail] <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_rspValid <= 1'b0;
         r_rspData  <= '0;
      end else begin
         if (w_store) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_drain) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_rspValid <= w_load;
         if (w_load) begin
            r_rspData <= w_loadData;
         end
      end
   end

endmodule

// File: tb/tb_store_buffer_lsu.sv
// Randomised and directed bench for store_buffer_lsu, checked every cycle
// against a queue-based model of the store buffer and the data RAM.
module tb_store_buffer_lsu;

   localparam int DEPTH = 4;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqValid;
   logic        reqWe;
   logic [15:0] reqAddr;
   logic [15:0] reqWdata;
   logic        reqReady;
   logic        rspValid;
   logic [15:0] rspData;
   logic        sbEmpty;
   logic [15:0] memAccessAddr;
   logic [15:0] memWriteData;
   logic        memWriteEn;
   logic        memRead;
   logic [15:0] memReadData;

   logic [15:0] envRam [256];
   logic [15:0] refRam [256];
   entry_t      modelQ [$];
   logic        expRspValid;
   logic [15:0] expRspData;
   int          checks = 0;
   int          errors = 0;

   store_buffer_lsu #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(reqValid),
      .req_we(reqWe),
      .req_addr(reqAddr),
      .req_wdata(reqWdata),
      .req_ready(reqReady),
      .rsp_valid(rspValid),
      .rsp_data(rspData),
      .sb_empty(sbEmpty),
      .mem_access_addr(memAccessAddr),
      .mem_write_data(memWriteData),
      .mem_write_en(memWriteEn),
      .mem_read(memRead),
      .mem_read_data(memReadData)
   );

   always #5 clk = ~clk;

   // The data RAM the unit drives: asynchronous read, synchronous write.
   assign memReadData = envRam[memAccessAddr[8:1]];
   always @(posedge clk) begin
      if (memWriteEn) envRam[memAccessAddr[8:1]] <= memWriteData;
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic modelReady();
      return !reset && (modelQ.size() < DEPTH);
   endfunction

   function automatic logic modelLoad();
      return reqValid && modelReady() && !reqWe;
   endfunction

   function automatic logic modelDrain();
      return !reset && !modelLoad() && (modelQ.size() > 0);
   endfunction

   // Newest matching buffered store wins, otherwise the RAM contents.
   function automatic logic [15:0] modelLoadValue(input logic [15:0] addr);
      for (int i = modelQ.size() - 1; i >= 0; i--) begin
         if (modelQ[i].addr[8:1] == addr[8:1]) return modelQ[i].data;
      end
      return refRam[addr[8:1]];
   endfunction

   // Compare every output mid-cycle, once inputs and combinational paths have settled.
   always @(negedge clk) begin
      logic [15:0] expAddr;
      logic [15:0] expData;
      expAddr = 16'h0000;
      expData = 16'h0000;
      if (modelLoad()) begin
         expAddr = reqAddr;
      end else if (modelDrain()) begin
         expAddr = modelQ[0].addr;
         expData = modelQ[0].data;
      end
      checkOutput("req_ready", {15'b0, reqReady}, {15'b0, modelReady()});
      checkOutput("mem_read", {15'b0, memRead}, {15'b0, modelLoad()});
      checkOutput("mem_write_en", {15'b0, memWriteEn}, {15'b0, modelDrain()});
      checkOutput("mem_access_addr", memAccessAddr, expAddr);
      checkOutput("mem_write_data", memWriteData, expData);
      checkOutput("sb_empty", {15'b0, sbEmpty}, {15'b0, modelQ.size() == 0});
      checkOutput("rsp_valid", {15'b0, rspValid}, {15'b0, expRspValid});
      if (expRspValid) checkOutput("rsp_data", rspData, expRspData);
   end

   // Advance the model with the inputs the DUT samples at this edge.
   always @(posedge clk) begin
      logic isLoad;
      logic isDrain;
      logic isStore;
      isLoad  = modelLoad();
      isDrain = modelDrain();
      isStore = reqValid && modelReady() && reqWe;
      if (reset) begin
         modelQ.delete();
         expRspValid = 1'b0;
         expRspData  = 16'h0000;
      end else begin
         expRspValid = isLoad;
         if (isLoad) expRspData = modelLoadValue(reqAddr);
         if (isDrain) begin
            refRam[modelQ[0].addr[8:1]] = modelQ[0].data;
            void'(modelQ.pop_front());
         end
         if (isStore) modelQ.push_back('{addr: reqAddr, data: reqWdata});
      end
   end

   task automatic applyStimulus(input logic rst, input logic v, input logic we,
                                input logic [15:0] a, input logic [15:0] d);
      @(posedge clk);
      #1;
      reset    = rst;
      reqValid = v;
      reqWe    = we;
      reqAddr  = a;
      reqWdata = d;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         envRam[i] = 16'h0000;
         refRam[i] = 16'h0000;
      end
      expRspValid = 1'b0;
      expRspData  = 16'h0000;
      reset    = 1'b1;
      reqValid = 1'b0;
      reqWe    = 1'b0;
      reqAddr  = 16'h0000;
      reqWdata = 16'h0000;
   end

   initial begin
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #1;
      checkOutput("reset req_ready", {15'b0, reqReady}, 16'h0000);
      checkOutput("reset sb_empty", {15'b0, sbEmpty}, 16'h0001);
      checkOutput("reset rsp_valid", {15'b0, rspValid}, 16'h0000);
      checkOutput("reset rsp_data", rspData, 16'h0000);
      checkOutput("reset mem_write_en", {15'b0, memWriteEn}, 16'h0000);

      idle();
      #1;
      checkOutput("ready after reset", {15'b0, reqReady}, 16'h0001);

      // Load from zeroed RAM.
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      idle();
      #1;
      checkOutput("first load valid", {15'b0, rspValid}, 16'h0001);
      checkOutput("first load data", rspData, 16'h0000);

      // Store then immediate load forwards from the buffer.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      idle();
      #1;
      checkOutput("forward BEEF", rspData, 16'hBEEF);
      idle();
      #1;
      checkOutput("drained empty", {15'b0, sbEmpty}, 16'h0001);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      idle();
      #1;
      checkOutput("RAM BEEF", rspData, 16'hBEEF);

      // Two stores to one word: youngest forwards.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1111);
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020, 16'h2222);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
      idle();
      #1;
      checkOutput("youngest wins", rspData, 16'h2222);

      // Twenty stores across pointer wraps, then back-to-back loads.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 16'(i * 2), 16'(i * 2) ^ 16'hA5A5);
      end
      for (int i = 0; i <= 20; i++) begin
         if (i < 20) applyStimulus(1'b0, 1'b1, 1'b0, 16'(i * 2), 16'h0000);
         else idle();
         if (i > 0) begin
            #1;
            checkOutput("wrap readback valid", {15'b0, rspValid}, 16'h0001);
            checkOutput("wrap readback", rspData, 16'((i - 1) * 2) ^ 16'hA5A5);
         end
      end

      // A buffered store is discarded by reset.
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0044, 16'h7777);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      idle();
      #1;
      checkOutput("discard empty", {15'b0, sbEmpty}, 16'h0001);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000);
      idle();
      #1;
      checkOutput("discarded store", rspData, 16'h0000);

      // Random traffic over a few words so forwarding and aliasing are frequent.
      for (int n = 0; n < 1500; n++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'hFE00) : 16'h0000;
         a = a | 16'($urandom_range(0, 15) << 1) | 16'($urandom_range(0, 1));
         applyStimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, 9) < 8,
                       $urandom_range(0, 1) == 1,
                       a, 16'($urandom));
      end
      repeat (4) idle();
      @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
